lfsr_chk: RTL

LFSR_CHK -- requirements
Module: lfsr_chk

---
 rtl/lfsr_pkg.sv | 13 +
 rtl/lfsr_chk.sv | 131 +++++++++++++
 2 files changed

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared PRBS16 step function, taps, default seed and checker state type.
package lfsr_pkg;
    localparam logic [15:0] LFSR_TAPS = 16'hB008;
    localparam logic [15:0] LFSR_SEED = 16'd1;
    typedef enum logic [1:0] {
        SEED   = 2'd0,
        SEARCH = 2'd1,
        LOCK   = 2'd2
    } chk_state_t;
    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return {x[14:0], ^(x & LFSR_TAPS)};
    endfunction
endpackage

// File: rtl/lfsr_chk.sv
// lfsr_chk: PRBS16 receive checker; seeds from incoming data, locks after a run of
// matches, then flywheels its reference and counts word and bit errors.
module lfsr_chk
    import lfsr_pkg::*;
#(
    parameter int GP_LOCK_CNT   = 4,
    parameter int GP_UNLOCK_CNT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        chk_en,
    input  logic [15:0] chk_data,
    input  logic        clr,
    output logic        lock,
    output logic        err,
    output logic [15:0] err_cnt,
    output logic [23:0] bit_err_cnt,
    output logic [1:0]  state
);
    localparam int LP_MW = $clog2(GP_LOCK_CNT + 1);
    localparam int LP_NW = $clog2(GP_UNLOCK_CNT + 1);

    chk_state_t       r_state, w_state_nxt;
    logic [15:0]      r_ref, w_ref_nxt;
    logic [LP_MW-1:0] r_match, w_match_nxt, w_match_inc;
    logic [LP_NW-1:0] r_miss, w_miss_nxt, w_miss_inc;
    logic [15:0]      r_ecnt, w_ecnt_nxt;
    logic [23:0]      r_bcnt, w_bcnt_nxt;
    logic             r_lock, r_err, w_err_nxt;
    logic [15:0]      w_next;
    logic             w_hit;
    logic [24:0]      w_bsum;

    function automatic logic [4:0] popcount(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) n += {4'd0, v[i]};
        return n;
    endfunction

    assign w_next      = lfsr_next(r_ref);
    assign w_hit       = chk_data == w_next;
    assign w_match_inc = r_match + 1'b1;
    assign w_miss_inc  = r_miss + 1'b1;
    // one spare bit catches overflow so the count can clamp instead of wrapping
    assign w_bsum      = {1'b0, r_bcnt} + {20'd0, popcount(chk_data ^ w_next)};

    always_comb begin
        w_state_nxt = r_state;
        w_ref_nxt   = r_ref;
        w_match_nxt = r_match;
        w_miss_nxt  = r_miss;
        w_ecnt_nxt  = r_ecnt;
        w_bcnt_nxt  = r_bcnt;
        w_err_nxt   = 1'b0;
        case (r_state)
            SEED: begin
                if (chk_en && chk_data != '0) begin
                    w_ref_nxt   = chk_data;
                    w_match_nxt = '0;
                    w_state_nxt = SEARCH;
                end
            end
            SEARCH: begin
                if (chk_en) begin
                    w_ref_nxt = chk_data;
                    if (w_hit && chk_data != '0) begin
                        w_match_nxt = w_match_inc;
                        if (w_match_inc == LP_MW'(GP_LOCK_CNT)) begin
                            w_state_nxt = LOCK;
                            w_miss_nxt  = '0;
                        end
                    end else begin
                        w_match_nxt = '0;
                    end
                end
            end
            LOCK: begin
                if (chk_en) begin
                    w_ref_nxt = w_next;
                    if (w_hit) begin
                        w_miss_nxt = '0;
                    end else begin
                        w_err_nxt  = 1'b1;
                        w_ecnt_nxt = &r_ecnt ? r_ecnt : r_ecnt + 1'b1;
                        w_bcnt_nxt = w_bsum[24] ? '1 : w_bsum[23:0];
                        w_miss_nxt = w_miss_inc;
                        if (w_miss_inc == LP_NW'(GP_UNLOCK_CNT)) begin
                            w_state_nxt = SEARCH;
                            w_ref_nxt   = chk_data;
                            w_match_nxt = '0;
                        end
                    end
                end
            end
            default: w_state_nxt = SEED;
        endcase
        if (clr) begin
            w_ecnt_nxt = '0;
            w_bcnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SEED;
            r_ref   <= '0;
            r_match <= '0;
            r_miss  <= '0;
            r_ecnt  <= '0;
            r_bcnt  <= '0;
            r_lock  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ref   <= w_ref_nxt;
            r_match <= w_match_nxt;
            r_miss  <= w_miss_nxt;
            r_ecnt  <= w_ecnt_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_lock  <= w_state_nxt == LOCK;
            r_err   <= w_err_nxt;
        end
    end

    assign lock        = r_lock;
    assign err         = r_err;
    assign err_cnt     = r_ecnt;
    assign bit_err_cnt = r_bcnt;
    assign state       = r_state;
endmodule
